// File: rtl/fnd_decoder.sv
// Receive-side decoder for a scanned 4-digit active-low FND bus.
// It settles each digit strobe, decodes its segments to a nibble and emits a full frame once all four slots are captured.
module fnd_decoder #(
    parameter int unsigned SETTLE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  fnd_com,
    input  logic [7:0]  fnd_data,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic        frame_err,
    output logic        valid
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned VALUE_W = 4 * DIGITS;

    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE);
    // Counter value seen on the sampling edge; SETTLE=1 samples on the change edge instead.
    localparam logic [CNT_W-1:0] SAMPLE_CNT = (SETTLE >= 2) ? CNT_W'(SETTLE - 2) : CNT_W'(0);
    localparam bit               SAMPLE_ON_CHANGE = (SETTLE == 1);

    logic [3:0]         com_prev_q,  com_prev_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [DIGITS-1:0]  mask_q,      mask_d;
    logic [VALUE_W-1:0] slot_val_q,  slot_val_d;
    logic [DIGITS-1:0]  slot_dp_q,   slot_dp_d;
    logic [DIGITS-1:0]  slot_err_q,  slot_err_d;
    logic [VALUE_W-1:0] value_q,     value_d;
    logic [DIGITS-1:0]  dp_q,        dp_d;
    logic               frame_err_q, frame_err_d;
    logic               valid_q,     valid_d;

    logic       com_legal_c;
    logic       com_changed_c;
    logic [1:0] slot_idx_c;
    logic       sample_c;
    logic [3:0] seg_nib_c;
    logic       seg_bad_c;

    // Digit select must be exactly one low bit.
    always_comb begin
        com_legal_c = 1'b0;
        slot_idx_c  = 2'd0;
        case (fnd_com)
            4'hE: begin com_legal_c = 1'b1; slot_idx_c = 2'd0; end
            4'hD: begin com_legal_c = 1'b1; slot_idx_c = 2'd1; end
            4'hB: begin com_legal_c = 1'b1; slot_idx_c = 2'd2; end
            4'h7: begin com_legal_c = 1'b1; slot_idx_c = 2'd3; end
            default: begin com_legal_c = 1'b0; slot_idx_c = 2'd0; end
        endcase
    end

    // Active-low seven-segment pattern back to a hex nibble.
    always_comb begin
        seg_nib_c = 4'h0;
        seg_bad_c = 1'b0;
        case (fnd_data[6:0])
            7'h40: seg_nib_c = 4'h0;
            7'h79: seg_nib_c = 4'h1;
            7'h24: seg_nib_c = 4'h2;
            7'h30: seg_nib_c = 4'h3;
            7'h19: seg_nib_c = 4'h4;
            7'h12: seg_nib_c = 4'h5;
            7'h02: seg_nib_c = 4'h6;
            7'h78: seg_nib_c = 4'h7;
            7'h00: seg_nib_c = 4'h8;
            7'h10: seg_nib_c = 4'h9;
            7'h08: seg_nib_c = 4'hA;
            7'h03: seg_nib_c = 4'hB;
            7'h46: seg_nib_c = 4'hC;
            7'h21: seg_nib_c = 4'hD;
            7'h06: seg_nib_c = 4'hE;
            7'h0E: seg_nib_c = 4'hF;
            default: begin
                seg_nib_c = 4'h0;
                seg_bad_c = 1'b1;
            end
        endcase
    end

    assign com_changed_c = (fnd_com != com_prev_q);

    always_comb begin
        if (SAMPLE_ON_CHANGE) begin
            sample_c = com_legal_c && com_changed_c;
        end else begin
            sample_c = com_legal_c && !com_changed_c && (cnt_q == SAMPLE_CNT);
        end
    end

    always_comb begin
        com_prev_d  = fnd_com;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        slot_val_d  = slot_val_q;
        slot_dp_d   = slot_dp_q;
        slot_err_d  = slot_err_q;
        value_d     = value_q;
        dp_d        = dp_q;
        frame_err_d = frame_err_q;
        valid_d     = 1'b0;

        if (!com_legal_c || com_changed_c) begin
            cnt_d = '0;
        end else if (cnt_q < SETTLE_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Publish a completed frame; a same-cycle sample then lands in the fresh frame.
        if (mask_q == 4'hF) begin
            value_d     = slot_val_q;
            dp_d        = slot_dp_q;
            frame_err_d = |slot_err_q;
            valid_d     = 1'b1;
            mask_d      = '0;
            slot_err_d  = '0;
        end

        if (sample_c) begin
            slot_val_d[{slot_idx_c, 2'b00} +: 4] = seg_nib_c;
            slot_dp_d[slot_idx_c]                = ~fnd_data[7];
            slot_err_d[slot_idx_c]               = seg_bad_c;
            mask_d[slot_idx_c]                   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            com_prev_q  <= 4'hF;
            cnt_q       <= '0;
            mask_q      <= '0;
            slot_val_q  <= '0;
            slot_dp_q   <= '0;
            slot_err_q  <= '0;
            value_q     <= '0;
            dp_q        <= '0;
            frame_err_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            com_prev_q  <= com_prev_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            slot_val_q  <= slot_val_d;
            slot_dp_q   <= slot_dp_d;
            slot_err_q  <= slot_err_d;
            value_q     <= value_d;
            dp_q        <= dp_d;
            frame_err_q <= frame_err_d;
            valid_q     <= valid_d;
        end
    end

    assign value     = value_q;
    assign dp        = dp_q;
    assign frame_err = frame_err_q;
    assign valid     = valid_q;

endmodule

// File: doc/fnd_decoder.md
# fnd_decoder

Receive-side counterpart of the 4-digit FND scan driver. Monitors the scanned common (digit-select) and segment lines, waits for each digit strobe to settle, and decodes the segment pattern back to a hex nibble. Once all four digit positions have been captured, it assembles a 16-bit value with per-digit decimal-point flags and issues a one-cycle valid strobe. It is used as an on-chip loopback monitor and self-checking bench companion for the FND display path.

## Interface

Parameters:
- SETTLE, default 4: consecutive cycles `fnd_com` must hold one stable one-hot-low code before `fnd_data` is sampled; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- fnd_com  input  4  digit select, active-low one-hot; bit0 is the ones digit, bit3 the thousands digit.
- fnd_data  input  8  segments, active-low; bit0..bit6 are segments a..g, bit7 is dp.
- value  output  16  last complete frame; nibble k is the digit selected by fnd_com[k].
- dp  output  4  last complete frame's dp flags (1 = dp lit), bit k for digit k.
- frame_err  output  1  last complete frame contained at least one undecodable pattern.
- valid  output  1  one-cycle pulse when value/dp/frame_err update.

## Operation

- Select check: `fnd_com` is legal only if exactly one bit is 0. The codes 4'hF (blank), 4'h0, and any value with more than one low bit are illegal. An illegal code clears the settle counter and re-arms capture.
- Settle counter (8 bits):
  - Increments while `fnd_com` is legal and equal to its previous-cycle value.
  - Clears to 0 on any change of `fnd_com`.
  - Saturates at SETTLE.
- Sample: on the cycle the counter reaches SETTLE-1 with `fnd_com` still unchanged, capture `fnd_data` into the selected digit slot once per dwell. Further cycles of the same dwell do not re-sample.
- Decode of `fnd_data[6:0]` to a nibble (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
  - Any other pattern, including blank 7F, gives nibble 0 and sets that slot's error bit.
- dp flag for a slot = ~fnd_data[7].
- Frame assembly:
  - A 4-bit capture mask sets bit k when slot k is sampled.
  - Re-sampling an already-captured slot before the frame completes overwrites that slot's nibble, dp, and error bit; the mask is unchanged.
  - When the mask becomes 4'b1111, all slot registers are copied to value/dp/frame_err (frame_err = OR of the slot error bits), valid pulses, and the mask and slot error bits clear.
- Scan order is irrelevant; any permutation completes a frame.

## Timing

- Reset values: value=16'h0000, dp=4'h0, frame_err=0, valid=0. Internally, mask, slot registers, error bits and settle counter are 0, and the previous-com register is 4'hF.
- Sample latency: `fnd_data` is sampled on the SETTLE-th rising edge after `fnd_com` changes to a legal code.
  - Example: with SETTLE=4, com changes before edge 0 and the sample occurs at edge 3.
  - `fnd_data` must be stable from the com change through that edge.
- Output latency: value/dp/frame_err and valid assert on the edge after the fourth distinct slot is sampled. valid is high for exactly one cycle; the outputs hold until the next frame.
- A dwell shorter than SETTLE cycles produces no sample. A com change on the sampling cycle itself cancels that sample.
- Reset asserted mid-frame discards the partial frame; no valid is produced for it.
- Reset and a frame completion in the same cycle: reset wins.
- Minimum frame period: 4 x SETTLE cycles plus 1.

## Test plan

- Reset: hold reset 2 cycles with random inputs -> value=0000, dp=0, frame_err=0, valid never high.
- Basic frame: SETTLE=4, 8-cycle dwells on com E,D,B,7 with data 99,B0,A4,F9 -> one valid pulse, value=16'h1234, dp=0, frame_err=0.
- Hex + dp: slots 0..3 receive 0E,21,46,08 with bit7 clear on slot 2 -> value=16'hACDF, dp=4'b0100.
- Glitch rejection: 3-cycle dwell on com E (less than SETTLE) carrying 80, then full dwells of 4 digits -> slot0 holds the later value. Inserted 4'hF and 4'h0 gaps cause no sample and no error.
- Bad pattern: slot1 data 7F (blank) -> valid with value nibble1=0 and frame_err=1. The next clean frame gives frame_err=0.
- Reset mid-frame: 2 slots captured, reset 1 cycle, then 4 full dwells -> exactly one valid, containing only post-reset data.
